pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core. Collects the load-use stall from the hazard detection unit, the EX branch redirect, multi-cycle EX unit status (divider) and I/D memory wait. Resolves them by fixed priority into per-stage pipeline register enables and bubble-insert flushes. Also tracks multi-cycle ops with a small FSM and keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage core. Resolves the memory waits, the
// multi-cycle EX hold, the EX branch redirect, the load-use hazard and the
// instruction-fetch wait by fixed priority. The result is a set of
// per-stage register enables and bubble-insert flushes.
// A small FSM tracks multi-cycle EX ops. Saturating counters record the
// number of stall cycles and the number of branch flushes.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   load_use_stall_i     load-use hazard for the instruction in ID
//   branch_taken_EX_i    taken branch/jump redirect resolved in EX
//   mc_start_EX_i        multi-cycle op occupies EX this cycle
//   mc_done_i            multi-cycle result valid (1-cycle pulse)
//   imem_wait_i          instruction memory not ready
//   dmem_wait_i          data memory not ready for the MEM access
//   perf_clr_i           synchronous clear of both performance counters
//   *_en_o               PC / pipeline register write enables
//   *_flush_o            write a bubble (NOP) into that register
//   mc_busy_o            multi-cycle FSM is not in RUN
//   stall_cycles_o       saturating count of cycles with pc_en_o = 0
//   flush_count_o        saturating count of applied branch flushes
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_use_stall_i,
   input  logic                 branch_taken_EX_i,
   input  logic                 mc_start_EX_i,
   input  logic                 mc_done_i,
   input  logic                 imem_wait_i,
   input  logic                 dmem_wait_i,
   input  logic                 perf_clr_i,
   output logic                 pc_en_o,
   output logic                 if_id_en_o,
   output logic                 id_ex_en_o,
   output logic                 ex_mem_en_o,
   output logic                 mem_wb_en_o,
   output logic                 if_id_flush_o,
   output logic                 id_ex_flush_o,
   output logic                 ex_mem_flush_o,
   output logic                 mc_busy_o,
   output logic [CNT_WIDTH-1:0] stall_cycles_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      MC_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  mc_hold_s;
   logic                  branch_flush_s;
   logic                  pc_en_s;
   logic                  if_id_en_s;
   logic                  id_ex_en_s;
   logic                  ex_mem_en_s;
   logic                  mem_wb_en_s;
   logic                  if_id_flush_s;
   logic                  id_ex_flush_s;
   logic                  ex_mem_flush_s;
   logic [CNT_WIDTH-1:0]  stall_cnt_r;
   logic [CNT_WIDTH-1:0]  flush_cnt_r;

   // The op in EX is held while it starts from RUN or while the unit is still
   // computing. MC_DONE is not a hold state: there the op only waits on dmem.
   assign mc_hold_s = ((state_r == RUN) && mc_start_EX_i) ||
                      ((state_r == MC_WAIT) && !mc_done_i);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic. A dmem freeze blocks every transition except
   // capturing the done pulse into MC_DONE so it is not lost.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (mc_start_EX_i && !dmem_wait_i) begin
               state_nxt_s = MC_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MC_WAIT: begin
            if (mc_done_i && dmem_wait_i) begin
               state_nxt_s = MC_DONE;
            end else if (mc_done_i) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = MC_WAIT;
            end
         end
         MC_DONE: begin
            if (!dmem_wait_i) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = MC_DONE;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // Priority resolution of enables and flushes. A flush is only ever raised
   // together with its register's enable so the bubble is actually written.
   always_comb begin
      pc_en_s        = 1'b1;
      if_id_en_s     = 1'b1;
      id_ex_en_s     = 1'b1;
      ex_mem_en_s    = 1'b1;
      mem_wb_en_s    = 1'b1;
      if_id_flush_s  = 1'b0;
      id_ex_flush_s  = 1'b0;
      ex_mem_flush_s = 1'b0;
      branch_flush_s = 1'b0;
      if (dmem_wait_i) begin
         pc_en_s     = 1'b0;
         if_id_en_s  = 1'b0;
         id_ex_en_s  = 1'b0;
         ex_mem_en_s = 1'b0;
         mem_wb_en_s = 1'b0;
      end else if (mc_hold_s) begin
         // Front end holds; a bubble goes to MEM so older work drains.
         pc_en_s        = 1'b0;
         if_id_en_s     = 1'b0;
         id_ex_en_s     = 1'b0;
         ex_mem_flush_s = 1'b1;
      end else if (branch_taken_EX_i) begin
         // Redirect wins over ID/IF hazards: those instructions are wrong-path.
         if_id_flush_s  = 1'b1;
         id_ex_flush_s  = 1'b1;
         branch_flush_s = 1'b1;
      end else if (load_use_stall_i) begin
         pc_en_s       = 1'b0;
         if_id_en_s    = 1'b0;
         id_ex_flush_s = 1'b1;
      end else if (imem_wait_i) begin
         pc_en_s       = 1'b0;
         if_id_flush_s = 1'b1;
      end else begin
         pc_en_s = 1'b1;
      end
   end

   // Saturating performance counters; clear overrides increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else if (perf_clr_i) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
         if (branch_flush_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end
      end
   end

   assign pc_en_o        = pc_en_s;
   assign if_id_en_o     = if_id_en_s;
   assign id_ex_en_o     = id_ex_en_s;
   assign ex_mem_en_o    = ex_mem_en_s;
   assign mem_wb_en_o    = mem_wb_en_s;
   assign if_id_flush_o  = if_id_flush_s;
   assign id_ex_flush_o  = id_ex_flush_s;
   assign ex_mem_flush_o = ex_mem_flush_s;
   assign mc_busy_o      = (state_r != RUN);
   assign stall_cycles_o = stall_cnt_r;
   assign flush_count_o  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   // Input vector: {load_use, branch, mc_start, mc_done, imem_wait, dmem_wait}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_LU   = 6'b100000;
   localparam logic [5:0] I_BR   = 6'b010000;
   localparam logic [5:0] I_MCS  = 6'b001000;
   localparam logic [5:0] I_MCD  = 6'b000100;
   localparam logic [5:0] I_IW   = 6'b000010;
   localparam logic [5:0] I_DW   = 6'b000001;

   // Control vector: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, busy}
   localparam logic [8:0] C_IDLE   = 9'b11111_000_0;
   localparam logic [8:0] C_IDLE_B = 9'b11111_000_1;
   localparam logic [8:0] C_FRZ    = 9'b00000_000_0;
   localparam logic [8:0] C_FRZ_B  = 9'b00000_000_1;
   localparam logic [8:0] C_MC     = 9'b00011_001_0;
   localparam logic [8:0] C_MC_B   = 9'b00011_001_1;
   localparam logic [8:0] C_BR     = 9'b11111_110_0;
   localparam logic [8:0] C_LU     = 9'b00111_010_0;
   localparam logic [8:0] C_IW     = 9'b01111_100_0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_use = 1'b0, branch = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
   logic        imem_wait = 1'b0, dmem_wait = 1'b0, perf_clr = 1'b0;

   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_fl, id_ex_fl, ex_mem_fl, mc_busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
   logic        if_id_fl4, id_ex_fl4, ex_mem_fl4, mc_busy4;
   logic [3:0]  stall_cnt4, flush_cnt4;

   int tests_run = 0;
   int fails = 0;

   logic [8:0] exp_q[$];
   string      name_q[$];

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall_i(load_use), .branch_taken_EX_i(branch),
      .mc_start_EX_i(mc_start), .mc_done_i(mc_done),
      .imem_wait_i(imem_wait), .dmem_wait_i(dmem_wait), .perf_clr_i(perf_clr),
      .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
      .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
      .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl), .ex_mem_flush_o(ex_mem_fl),
      .mc_busy_o(mc_busy), .stall_cycles_o(stall_cnt), .flush_count_o(flush_cnt)
   );

   pipeline_ctrl #(.CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall_i(load_use), .branch_taken_EX_i(branch),
      .mc_start_EX_i(mc_start), .mc_done_i(mc_done),
      .imem_wait_i(imem_wait), .dmem_wait_i(dmem_wait), .perf_clr_i(perf_clr),
      .pc_en_o(pc_en4), .if_id_en_o(if_id_en4), .id_ex_en_o(id_ex_en4),
      .ex_mem_en_o(ex_mem_en4), .mem_wb_en_o(mem_wb_en4),
      .if_id_flush_o(if_id_fl4), .id_ex_flush_o(id_ex_fl4), .ex_mem_flush_o(ex_mem_fl4),
      .mc_busy_o(mc_busy4), .stall_cycles_o(stall_cnt4), .flush_count_o(flush_cnt4)
   );

   wire [8:0] ctrl  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_fl, id_ex_fl, ex_mem_fl, mc_busy};
   wire [8:0] ctrl4 = {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4,
                       if_id_fl4, id_ex_fl4, ex_mem_fl4, mc_busy4};

   // Drive one cycle of inputs, queue the expected controls, check them at the
   // falling edge, and return just after the following rising edge.
   task automatic cyc(input logic [5:0] in, input logic clr, input logic [8:0] exp,
                      input string nm);
      logic [8:0] e;
      string      n;
      {load_use, branch, mc_start, mc_done, imem_wait, dmem_wait} = in;
      perf_clr = clr;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(negedge clk);
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests_run++;
      if (ctrl !== e) begin
         fails++;
         $display("FAIL %s: ctrl got %b want %b", n, ctrl, e);
      end
      tests_run++;
      if (ctrl4 !== e) begin
         fails++;
         $display("FAIL %s(w4): ctrl got %b want %b", n, ctrl4, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests_run++;
      if (ctrl !== C_IDLE || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         fails++;
         $display("FAIL reset_state: ctrl %b stall %0d flush %0d want %b 0 0",
                  ctrl, stall_cnt, flush_cnt, C_IDLE);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(I_NONE, 1'b0, C_IDLE, "reset_idle");
      tests_run++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         fails++;
         $display("FAIL reset_hold_counters: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_load_use();
      cyc(I_NONE, 1'b1, C_IDLE, "lu_clr");
      cyc(I_LU, 1'b0, C_LU, "lu_stall");
      tests_run++;
      if (stall_cnt !== 32'd1) begin
         fails++;
         $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
      end
      cyc(I_IW, 1'b0, C_IW, "imem_wait");
      tests_run++;
      if (stall_cnt !== 32'd2 || flush_cnt !== 32'd0) begin
         fails++;
         $display("FAIL iw_cnt: stall %0d flush %0d want 2 0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_priority();
      cyc(I_NONE, 1'b1, C_IDLE, "prio_clr");
      cyc(I_LU | I_BR, 1'b0, C_BR, "br_over_lu");
      tests_run++;
      if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
         fails++;
         $display("FAIL br_over_lu_cnt: flush %0d stall %0d want 1 0", flush_cnt, stall_cnt);
      end
      cyc(I_IW | I_BR, 1'b0, C_BR, "br_over_iw");
      cyc(I_LU | I_IW, 1'b0, C_LU, "lu_over_iw");
      cyc(I_DW | I_BR | I_LU, 1'b0, C_FRZ, "dw_over_br");
      cyc(I_DW | I_MCS, 1'b0, C_FRZ, "dw_over_mcs");
      cyc(I_MCD, 1'b0, C_IDLE, "done_ignored_run");
      tests_run++;
      if (flush_cnt !== 32'd2 || stall_cnt !== 32'd3) begin
         fails++;
         $display("FAIL prio_cnt: flush %0d stall %0d want 2 3", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_multicycle();
      cyc(I_NONE, 1'b1, C_IDLE, "mc_clr");
      cyc(I_MCS, 1'b0, C_MC, "mc_start");
      cyc(I_NONE, 1'b0, C_MC_B, "mc_wait1");
      cyc(I_MCS | I_BR, 1'b0, C_MC_B, "mc_wait2_ign");
      cyc(I_NONE, 1'b0, C_MC_B, "mc_wait3");
      cyc(I_MCD | I_BR, 1'b0, C_BR | 9'b00000_000_1, "mc_release_br");
      cyc(I_NONE, 1'b0, C_IDLE, "mc_after");
      tests_run++;
      if (stall_cnt !== 32'd4 || flush_cnt !== 32'd1) begin
         fails++;
         $display("FAIL mc_cnt: stall %0d flush %0d want 4 1", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_mc_done_dmem();
      cyc(I_NONE, 1'b1, C_IDLE, "mcd_clr");
      cyc(I_MCS, 1'b0, C_MC, "mcd_start");
      cyc(I_NONE, 1'b0, C_MC_B, "mcd_wait");
      cyc(I_MCD | I_DW, 1'b0, C_FRZ_B, "mcd_done_dw");
      cyc(I_DW, 1'b0, C_FRZ_B, "mcd_hold1");
      cyc(I_DW | I_MCS, 1'b0, C_FRZ_B, "mcd_hold2");
      cyc(I_DW, 1'b0, C_FRZ_B, "mcd_hold3");
      cyc(I_MCS | I_LU, 1'b0, C_LU | 9'b00000_000_1, "mcd_release");
      cyc(I_NONE, 1'b0, C_IDLE, "mcd_run");
      tests_run++;
      if (stall_cnt !== 32'd7) begin
         fails++;
         $display("FAIL mcd_stall_cnt: got %0d want 7", stall_cnt);
      end
   endtask

   task automatic test_reset_mid_mc();
      cyc(I_MCS, 1'b0, C_MC, "rst_mc_start");
      cyc(I_NONE, 1'b0, C_MC_B, "rst_mc_wait");
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (mc_busy !== 1'b0 || stall_cnt !== 32'd0 || pc_en !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_mc: busy %b stall %0d pc_en %b want 0 0 1",
                  mc_busy, stall_cnt, pc_en);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(I_NONE, 1'b0, C_IDLE, "rst_after");
   endtask

   task automatic test_saturation();
      cyc(I_NONE, 1'b1, C_IDLE, "sat_clr");
      for (int i = 0; i < 20; i++) cyc(I_IW, 1'b0, C_IW, "sat_iw");
      tests_run++;
      if (stall_cnt4 !== 4'd15) begin
         fails++;
         $display("FAIL sat_w4: got %0d want 15", stall_cnt4);
      end
      tests_run++;
      if (stall_cnt !== 32'd20) begin
         fails++;
         $display("FAIL sat_w32: got %0d want 20", stall_cnt);
      end
      for (int i = 0; i < 17; i++) cyc(I_BR, 1'b0, C_BR, "sat_br");
      tests_run++;
      if (flush_cnt4 !== 4'd15 || flush_cnt !== 32'd17) begin
         fails++;
         $display("FAIL sat_flush: w4 %0d w32 %0d want 15 17", flush_cnt4, flush_cnt);
      end
      cyc(I_IW | I_BR, 1'b1, C_BR, "sat_clr_over_inc");
      tests_run++;
      if (stall_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         fails++;
         $display("FAIL sat_clear: w4 %0d/%0d w32 %0d/%0d want 0",
                  stall_cnt4, flush_cnt4, stall_cnt, flush_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_multicycle();
      test_mc_done_dmem();
      test_reset_mid_mc();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
